dma_scheduler: RTL and testbench
================================

# dma_scheduler

- Shares the single DMA engine among `NREQ` requesters, such as the PCIe mailbox, the network RX path and CPU software.
- Per job: arbitrates round-robin, latches the winner's descriptor, and programs the DMA engine through its memory-mapped config port (Src 0x0, Dst 0x4, Len 0x8, Start 0xC).
- Waits for the engine's completion interrupt, then reports completion to the owning requester.
- A watchdog catches a DMA job that never completes and halts the scheduler.

## Interface

Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `TO_W`, 16: watchdog counter width. Timeout fires after 2^TO_W − 1 cycles in WAIT.

Ports:
- `clk`  in  1: single clock. All logic is rising-edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req`  in  NREQ: per-requester job request. Level; held high until `ack`.
- `req_src`  in  32·NREQ: source pointer. Slice i = bits [32i+31:32i].
- `req_dst`  in  32·NREQ: destination byte address.
- `req_len`  in  32·NREQ: length in 32-bit words.
- `ack`  out  NREQ: one-cycle pulse; the descriptor was latched.
- `done`  out  NREQ: one-cycle pulse; the job completed.
- `err`  out  1: one-cycle pulse coincident with the `done` of a timed-out job.
- `fault`  out  1: sticky after a timeout; cleared only by reset.
- `busy`  out  1: high whenever the state is not IDLE.
- `cur_id`  out  3: index of the requester being served. Valid while `busy`.
- `cfg_addr`  out  32: DMA config address.
- `cfg_wdata`  out  32: DMA config write data.
- `cfg_we`  out  1: DMA config write strobe.
- `irq_done`  in  1: completion pulse from the DMA engine.

## Operation

States: IDLE, W_SRC, W_DST, W_LEN, W_START, WAIT, DONE, HALT.

**IDLE**
- If any `req` bit is set, the arbiter picks the winner at the next edge. The search starts at `last_id+1` modulo NREQ.
- At that edge: latch the winner's src/dst/len, set `cur_id` and `last_id` to the winner, pulse `ack[winner]`, go to W_SRC.
- `last_id` resets to NREQ−1, so requester 0 wins first after reset.

**Config writes (Moore outputs, driven from the state register)**
- W_SRC: `cfg_we`=1, `cfg_addr`=0x0, `cfg_wdata`=src.
- W_DST: `cfg_we`=1, `cfg_addr`=0x4, `cfg_wdata`=dst.
- W_LEN: `cfg_we`=1, `cfg_addr`=0x8, `cfg_wdata`=len.
- W_START: `cfg_we`=1, `cfg_addr`=0xC, `cfg_wdata`=0x1.
- Each state lasts one cycle and advances unconditionally.

**WAIT**
- `cfg_we`=0. The watchdog clears on entry and increments each cycle.
- `irq_done`=1: go to DONE with err=0.
- Watchdog reaches all-ones: go to DONE with err=1 and set `fault`.

**DONE**
- One cycle. Pulse `done[cur_id]`, and `err` if the job timed out.
- Next state: HALT if `fault`, else IDLE.

**HALT**
- Absorbing until reset. No `ack`, no `cfg_we`; `busy`=1.
- Rationale: the engine ignores config writes while it is still busy.

**General rules**
- `req_len`=0 is passed through unchanged. The engine completes it in one cycle.
- Requests are never dropped. A requester whose `req` stays high is served when the round-robin pointer reaches it.
- `irq_done` outside WAIT is ignored and never creates a spurious `done`.
- The descriptor is sampled only at the `ack` edge. Changes to `req_*` after `ack` have no effect on the job in flight.
- A `req` bit falling before `ack` withdraws that request cleanly.

## Timing

**Reset values**
- State = IDLE.
- `ack`, `done`, `err`, `fault`, `busy`, `cfg_we` = 0.
- `cfg_addr`, `cfg_wdata` = 0. `cur_id` = 0. `last_id` = NREQ−1.
- Reset mid-job returns to IDLE immediately and `cfg_we` drops asynchronously. Resetting the DMA engine is the integrator's responsibility.

**Latency** (request seen in IDLE at cycle 0)
- Cycle 1: `ack`, W_SRC.
- Cycles 1–4: the four config writes.
- Cycle 5 onward: WAIT.
- With the one-word-per-cycle engine, `irq_done` arrives at cycle L+6, `done` at L+7, and IDLE at L+8.
- Back-to-back jobs: the next `ack` comes no earlier than 2 cycles after `done`.

**Watchdog**
- Timeout `done`/`err` occurs 2^TO_W cycles after WAIT entry.

## Test plan

- **Single job:** `req[0]`, src=0x1000, dst=0x2000, len=3 → `ack[0]` at cycle 1; writes (0x0,0x1000), (0x4,0x2000), (0x8,3), (0xC,1) on cycles 1–4; engine writes 0x2000/0x2004/0x2008; `done[0]` at cycle 10.
- **Round-robin:** `req`=4'b1111 held, len=1 each → ack order 0,1,2,3,0. Every `done[i]` precedes the next `ack`. No overlapping `cfg_we` bursts.
- **Zero length:** `req[2]`, len=0 → writes (0x8,0); `done[2]` at cycle 7; no memory writes.
- **Timeout:** TO_W=4, stub engine never asserts `irq_done` → `done[id]` and `err` pulse 16 cycles after WAIT entry; `fault` stays 1; a later `req` gets no `ack` until `reset_n` pulses low.
- **Reset mid-job:** `reset_n` low during W_DST → `cfg_we` 0 immediately, all outputs at reset values; after release `req[1]` is granted before `req[3]`.
- **Spurious interrupt:** `irq_done` pulse while IDLE or in W_LEN → no `done`, no state disturbance; the following job completes normally.

Source files
------------

// File: rtl/dma_scheduler.sv
// Purpose: round-robin share of one DMA engine among NREQ requesters; programs src/dst/len/start, waits for irq, reports done.
// Latency: ack 1 cycle after a request is seen in IDLE; config writes on cycles 1-4; done one cycle after irq_done (or watchdog expiry).
// Backpressure: req is level and held until ack; no new grant until the scheduler returns to IDLE (never again after a timeout).
module dma_scheduler #(
    parameter int NREQ = 4,
    parameter int TO_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   req_src,
    input  logic [32*NREQ-1:0]   req_dst,
    input  logic [32*NREQ-1:0]   req_len,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic                 fault,
    output logic                 busy,
    output logic [2:0]           cur_id,
    output logic [31:0]          cfg_addr,
    output logic [31:0]          cfg_wdata,
    output logic                 cfg_we,
    input  logic                 irq_done
);

    typedef enum logic [2:0] {
        IDLE, W_SRC, W_DST, W_LEN, W_START, WAIT, DONE, HALT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     src_q;
    logic [31:0]     dst_q;
    logic [31:0]     len_q;
    logic [2:0]      last_id;
    logic [TO_W-1:0] wd_cnt;
    logic            to_flag;
    logic            grant_vld;
    logic [2:0]      grant_id;
    logic            wd_expired;

    // Watchdog expiry only counts when the engine did not complete in the same cycle.
    assign wd_expired = (state == WAIT) && !irq_done && (wd_cnt == '1);
    assign busy       = (state != IDLE);

    // Round-robin search starting one past the last winner; the lowest offset wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int i = NREQ; i >= 1; i--) begin
            if (req[(int'(last_id) + i) % NREQ]) begin
                grant_vld = 1'b1;
                grant_id  = 3'((int'(last_id) + i) % NREQ);
            end
        end
    end

    // Next-state logic: the config writes advance unconditionally, WAIT ends on irq or watchdog.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = W_SRC;
            W_SRC:   state_nxt = W_DST;
            W_DST:   state_nxt = W_LEN;
            W_LEN:   state_nxt = W_START;
            W_START: state_nxt = WAIT;
            WAIT:    if (irq_done || (wd_cnt == '1)) state_nxt = DONE;
            DONE:    state_nxt = fault ? HALT : IDLE;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded from the state register, so reset drops cfg_we immediately.
    always_comb begin
        cfg_we    = 1'b0;
        cfg_addr  = 32'h0;
        cfg_wdata = 32'h0;
        done      = '0;
        err       = 1'b0;
        case (state)
            W_SRC: begin
                cfg_we    = 1'b1;
                cfg_addr  = 32'h0;
                cfg_wdata = src_q;
            end
            W_DST: begin
                cfg_we    = 1'b1;
                cfg_addr  = 32'h4;
                cfg_wdata = dst_q;
            end
            W_LEN: begin
                cfg_we    = 1'b1;
                cfg_addr  = 32'h8;
                cfg_wdata = len_q;
            end
            W_START: begin
                cfg_we    = 1'b1;
                cfg_addr  = 32'hC;
                cfg_wdata = 32'h1;
            end
            DONE: begin
                done = NREQ'(1) << cur_id;
                err  = to_flag;
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Grant: latch the descriptor and owner, pulse ack for one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack     <= '0;
            cur_id  <= '0;
            last_id <= 3'(NREQ - 1);
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
        end else begin
            ack <= '0;
            if (state == IDLE && grant_vld) begin
                ack     <= NREQ'(1) << grant_id;
                cur_id  <= grant_id;
                last_id <= grant_id;
                src_q   <= req_src[int'(grant_id)*32 +: 32];
                dst_q   <= req_dst[int'(grant_id)*32 +: 32];
                len_q   <= req_len[int'(grant_id)*32 +: 32];
            end
        end
    end

    // Watchdog: cleared entering WAIT, counts each WAIT cycle; expiry marks the job and sets the sticky fault.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt  <= '0;
            to_flag <= 1'b0;
            fault   <= 1'b0;
        end else begin
            if (state == W_START)   wd_cnt <= '0;
            else if (state == WAIT) wd_cnt <= wd_cnt + TO_W'(1);
            if (state == WAIT)      to_flag <= wd_expired;
            if (wd_expired)         fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dma_scheduler.sv
// Purpose: scoreboard bench for dma_scheduler with a behavioural one-word-per-cycle engine.
// Latency: checks ack/done cycle offsets against the documented timing.
// Backpressure: requesters hold req until ack; engine model can be disabled to force a watchdog timeout.
module tb_dma_scheduler;

    localparam int NREQ = 4;
    localparam int TO_W = 4;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [32*NREQ-1:0]  req_src = '0;
    logic [32*NREQ-1:0]  req_dst = '0;
    logic [32*NREQ-1:0]  req_len = '0;
    logic [NREQ-1:0]     ack;
    logic [NREQ-1:0]     done;
    logic                err;
    logic                fault;
    logic                busy;
    logic [2:0]          cur_id;
    logic [31:0]         cfg_addr;
    logic [31:0]         cfg_wdata;
    logic                cfg_we;
    logic                irq_done;
    logic                eng_irq = 1'b0;
    logic                spur_irq = 1'b0;
    bit                  eng_en = 1'b1;

    assign irq_done = eng_irq | spur_irq;

    dma_scheduler #(.NREQ(NREQ), .TO_W(TO_W)) dut (
        .clk(clk), .reset_n(reset_n), .req(req),
        .req_src(req_src), .req_dst(req_dst), .req_len(req_len),
        .ack(ack), .done(done), .err(err), .fault(fault), .busy(busy),
        .cur_id(cur_id), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_we(cfg_we), .irq_done(irq_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard queues
    int          exp_ack_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          exp_done_q[$];
    logic        exp_err_q[$];

    task automatic push_job(input int id, input logic [31:0] s, input logic [31:0] d,
                            input logic [31:0] l, input logic e);
        exp_ack_q.push_back(id);
        exp_addr_q.push_back(32'h0); exp_data_q.push_back(s);
        exp_addr_q.push_back(32'h4); exp_data_q.push_back(d);
        exp_addr_q.push_back(32'h8); exp_data_q.push_back(l);
        exp_addr_q.push_back(32'hC); exp_data_q.push_back(32'h1);
        exp_done_q.push_back(id);
        exp_err_q.push_back(e);
    endtask

    task automatic set_desc(input int id, input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        req_src[id*32 +: 32] = s;
        req_dst[id*32 +: 32] = d;
        req_len[id*32 +: 32] = l;
    endtask

    // Monitor: compares every ack, config write and done against the scoreboard.
    int in_flight = 0;
    int last_done = -100;
    initial begin
        int id;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_ack_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
                exp_done_q.delete(); exp_err_q.delete();
                in_flight = 0;
                last_done = -100;
            end else begin
                if (ack != 0) begin
                    if (exp_ack_q.size() == 0) chk("ack_unexpected", 32'(ack), 0);
                    else begin
                        id = exp_ack_q.pop_front();
                        chk("ack_id", 32'(ack), 32'(1 << id));
                        chk("ack_overlap", 32'(in_flight), 0);
                        chk("ack_gap_ge2", 32'(cyc - last_done >= 2), 1);
                        in_flight = 1;
                    end
                end
                if (cfg_we) begin
                    if (exp_addr_q.size() == 0) chk("cfg_unexpected", 32'(cfg_we), 0);
                    else begin
                        chk("cfg_addr", cfg_addr, exp_addr_q.pop_front());
                        chk("cfg_wdata", cfg_wdata, exp_data_q.pop_front());
                    end
                end
                if (done != 0) begin
                    if (exp_done_q.size() == 0) chk("done_unexpected", 32'(done), 0);
                    else begin
                        id = exp_done_q.pop_front();
                        chk("done_id", 32'(done), 32'(1 << id));
                        chk("done_err", 32'(err), 32'(exp_err_q.pop_front()));
                        in_flight = 0;
                        last_done = cyc;
                    end
                end else if (err) begin
                    chk("err_without_done", 32'(err), 0);
                end
            end
        end
    end

    // Engine model: irq_done asserted L+2 cycles after the start write is seen.
    initial begin
        int ecnt;
        int elen;
        ecnt = 0;
        elen = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                ecnt = 0;
                eng_irq = 1'b0;
            end else begin
                eng_irq = 1'b0;
                if (ecnt > 0) begin
                    ecnt--;
                    if (ecnt == 0) eng_irq = 1'b1;
                end
                if (cfg_we && cfg_addr == 32'h8) elen = int'(cfg_wdata);
                if (cfg_we && cfg_addr == 32'hC && eng_en) ecnt = elen + 2;
            end
        end
    end

    task automatic start_req(input logic [NREQ-1:0] mask, output int t0);
        @(posedge clk);
        #1;
        req = req | mask;
        t0 = cyc;
    endtask

    task automatic wait_ack(input int max, input bit drop, output int t);
        t = -1;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (ack != 0) begin
                t = cyc;
                if (drop) req = req & ~ack;
                break;
            end
        end
    endtask

    task automatic wait_done(input int max, output int t);
        t = -1;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (done != 0) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t0;
        int t;
        int nack;
        int ncfg;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cfg_we", 32'(cfg_we), 0);
        chk("rst_cfg_addr", cfg_addr, 0);
        chk("rst_cfg_wdata", cfg_wdata, 0);
        chk("rst_cur_id", 32'(cur_id), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single job on requester 0
        set_desc(0, 32'h1000, 32'h2000, 32'd3);
        push_job(0, 32'h1000, 32'h2000, 32'd3, 1'b0);
        start_req(4'b0001, t0);
        wait_ack(20, 1'b1, t);
        chk("single_ack_lat", 32'(t - t0), 1);
        wait_done(40, t);
        chk("single_done_lat", 32'(t - t0), 10);
        @(negedge clk);
        chk("single_idle_after", 32'(busy), 0);

        // Zero-length job on requester 2
        set_desc(2, 32'hA0, 32'hB0, 32'd0);
        push_job(2, 32'hA0, 32'hB0, 32'd0, 1'b0);
        start_req(4'b0100, t0);
        wait_ack(20, 1'b1, t);
        chk("zero_ack_lat", 32'(t - t0), 1);
        wait_done(40, t);
        chk("zero_done_lat", 32'(t - t0), 7);

        // Spurious irq while IDLE
        repeat (2) @(posedge clk);
        #1;
        spur_irq = 1'b1;
        @(posedge clk);
        #1;
        spur_irq = 1'b0;
        repeat (3) @(negedge clk);
        chk("spur_idle_busy", 32'(busy), 0);

        // Spurious irq during W_LEN, job still completes on time
        set_desc(1, 32'h3000, 32'h4000, 32'd2);
        push_job(1, 32'h3000, 32'h4000, 32'd2, 1'b0);
        start_req(4'b0010, t0);
        wait_ack(20, 1'b1, t);
        chk("spur_ack_lat", 32'(t - t0), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("spur_in_wlen", cfg_addr, 32'h8);
        spur_irq = 1'b1;
        @(posedge clk);
        #1;
        spur_irq = 1'b0;
        wait_done(40, t);
        chk("spur_done_lat", 32'(t - t0), 9);

        // Round-robin with all requesters held
        do_reset();
        for (int i = 0; i < NREQ; i++)
            set_desc(i, 32'h100 * (i + 1), 32'h8000 + 32'h10 * i, 32'd1);
        push_job(0, 32'h100, 32'h8000, 32'd1, 1'b0);
        push_job(1, 32'h200, 32'h8010, 32'd1, 1'b0);
        push_job(2, 32'h300, 32'h8020, 32'd1, 1'b0);
        push_job(3, 32'h400, 32'h8030, 32'd1, 1'b0);
        push_job(0, 32'h100, 32'h8000, 32'd1, 1'b0);
        @(posedge clk);
        #1;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(60, 1'b0, t);
            chk("rr_ack_seen", 32'(t >= 0), 1);
        end
        req = '0;
        wait_done(40, t);
        chk("rr_acks_drained", 32'(exp_ack_q.size()), 0);
        chk("rr_dones_drained", 32'(exp_done_q.size()), 0);

        // Reset during W_DST
        set_desc(3, 32'h5000, 32'h6000, 32'd4);
        push_job(3, 32'h5000, 32'h6000, 32'd4, 1'b0);
        repeat (2) @(posedge clk);
        start_req(4'b1000, t0);
        wait_ack(20, 1'b1, t);
        @(posedge clk);
        #1;
        chk("mid_in_wdst", cfg_addr, 32'h4);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_cfg_we", 32'(cfg_we), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_cfg_addr", cfg_addr, 0);
        chk("mid_rst_cur_id", 32'(cur_id), 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        set_desc(1, 32'h7100, 32'h7200, 32'd1);
        set_desc(3, 32'h7300, 32'h7400, 32'd2);
        push_job(1, 32'h7100, 32'h7200, 32'd1, 1'b0);
        push_job(3, 32'h7300, 32'h7400, 32'd2, 1'b0);
        req = 4'b1010;
        wait_ack(20, 1'b1, t);
        wait_ack(40, 1'b1, t);
        chk("mid_second_ack_seen", 32'(t >= 0), 1);
        wait_done(40, t);
        chk("mid_done_seen", 32'(t >= 0), 1);

        // Watchdog timeout: engine never answers
        repeat (2) @(posedge clk);
        eng_en = 1'b0;
        set_desc(2, 32'h9000, 32'h9100, 32'd5);
        push_job(2, 32'h9000, 32'h9100, 32'd5, 1'b1);
        start_req(4'b0100, t0);
        wait_ack(20, 1'b1, t);
        chk("to_ack_lat", 32'(t - t0), 1);
        wait_done(60, t);
        chk("to_done_lat", 32'(t - t0), 21);
        chk("to_fault_at_done", 32'(fault), 1);
        set_desc(0, 32'hC000, 32'hD000, 32'd1);
        req = 4'b0001;
        nack = 0;
        ncfg = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ack != 0) nack++;
            if (cfg_we) ncfg++;
        end
        chk("halt_no_ack", 32'(nack), 0);
        chk("halt_no_cfg", 32'(ncfg), 0);
        chk("halt_fault_sticky", 32'(fault), 1);
        chk("halt_busy", 32'(busy), 1);

        // Reset clears the halt; held request is then served
        eng_en = 1'b1;
        do_reset();
        push_job(0, 32'hC000, 32'hD000, 32'd1, 1'b0);
        chk("post_rst_fault", 32'(fault), 0);
        wait_ack(20, 1'b1, t);
        chk("post_rst_ack_seen", 32'(t >= 0), 1);
        wait_done(40, t);
        chk("post_rst_done_seen", 32'(t >= 0), 1);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
